simple_uart: RTL and testbench



---
 rtl/simple_uart_pkg.sv | 46 ++++
 rtl/simple_uart_rx.sv | 105 ++++++++++
 rtl/simple_uart.sv | 101 ++++++++++
 tb/tb_simple_uart.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_uart_pkg.sv
// -----------------------------------------------------------------------------
// simple_uart_pkg
// Shared types and constants for the simple_uart 8N1 UART.
//   - rx_state_e : receive FSM states (IDLE, START, BIT0..BIT7, STOP)
//   - FRAME_BITS : start + 8 data + stop
//   - DUMMY_BITS : idle-high bit times sent after reset or a divider change
//   - RX_EMPTY   : read value of an empty receive buffer
//   - merge_lanes: byte-lane merge used by the divider register
// -----------------------------------------------------------------------------
package simple_uart_pkg;

    localparam int FRAME_BITS = 10;
    localparam int DUMMY_BITS = 15;
    localparam logic [31:0] RX_EMPTY = 32'hFFFF_FFFF;

    typedef enum logic [3:0] {
        RX_IDLE  = 4'd0,
        RX_START = 4'd1,
        RX_BIT0  = 4'd2,
        RX_BIT1  = 4'd3,
        RX_BIT2  = 4'd4,
        RX_BIT3  = 4'd5,
        RX_BIT4  = 4'd6,
        RX_BIT5  = 4'd7,
        RX_BIT6  = 4'd8,
        RX_BIT7  = 4'd9,
        RX_STOP  = 4'd10
    } rx_state_e;

    // Replace each byte lane of old_val whose enable is set with the same lane of new_val.
    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  lane_we
    );
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (lane_we[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/simple_uart_rx.sv
// -----------------------------------------------------------------------------
// simple_uart_rx
// Receive side of simple_uart: start detection, mid-bit sampling FSM,
// 8-bit LSB-first shifter and a single-byte receive buffer.
// Ports:
//   clk        in   system clock
//   resetn     in   synchronous reset, active-low
//   i_rx       in   serial receive line (idles high)
//   i_cfg_div  in   divider; bit time is i_cfg_div+2 clocks
//   i_dat_re   in   read strobe, consumes the buffered byte
//   o_dat_do   out  {24'h0, byte} when valid, else all ones
// Build option: SIMPLE_UART_RX_SYNC_EN inserts a 2-flop synchronizer
// (reset to 1) in front of the FSM, delaying start detection by 2 clocks.
// -----------------------------------------------------------------------------
module simple_uart_rx
    import simple_uart_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_rx,
    input  logic [31:0] i_cfg_div,
    input  logic        i_dat_re,
    output logic [31:0] o_dat_do
);

    logic      w_rx;
    rx_state_e r_state;
    logic [31:0] r_cnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_buf;
    logic        r_valid;

`ifdef SIMPLE_UART_RX_SYNC_EN
    logic [1:0] r_rx_sync;

    // Two-stage synchronizer for the asynchronous serial input.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rx_sync <= 2'b11;
        end else begin
            r_rx_sync <= {r_rx_sync[0], i_rx};
        end
    end

    assign w_rx = r_rx_sync[1];
`else
    assign w_rx = i_rx;
`endif

    // Receive FSM, bit timer, shifter and buffer.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= RX_IDLE;
            r_cnt   <= 32'd0;
            r_shift <= 8'd0;
            r_buf   <= 8'd0;
            r_valid <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
            // A read consumes the byte; a byte completing this same cycle overrides it below.
            if (i_dat_re) begin
                r_valid <= 1'b0;
            end
            case (r_state)
                RX_IDLE: begin
                    if (!w_rx) begin
                        r_state <= RX_START;
                        r_cnt   <= 32'd0;
                    end
                end
                RX_START: begin
                    // Half a bit time into the start bit: later samples land mid-bit.
                    if ({r_cnt, 1'b0} > {1'b0, i_cfg_div}) begin
                        r_state <= RX_BIT0;
                        r_cnt   <= 32'd0;
                    end
                end
                RX_BIT0, RX_BIT1, RX_BIT2, RX_BIT3,
                RX_BIT4, RX_BIT5, RX_BIT6, RX_BIT7: begin
                    if (r_cnt > i_cfg_div) begin
                        r_shift <= {w_rx, r_shift[7:1]};
                        r_state <= rx_state_e'(r_state + 4'd1);
                        r_cnt   <= 32'd0;
                    end
                end
                RX_STOP: begin
                    // Stop level is not checked; an unread byte is overwritten.
                    if (r_cnt > i_cfg_div) begin
                        r_buf   <= r_shift;
                        r_valid <= 1'b1;
                        r_state <= RX_IDLE;
                        r_cnt   <= 32'd0;
                    end
                end
                default: begin
                    r_state <= RX_IDLE;
                    r_cnt   <= 32'd0;
                end
            endcase
        end
    end

    assign o_dat_do = r_valid ? {24'h00_0000, r_buf} : RX_EMPTY;

endmodule

// File: rtl/simple_uart.sv
// -----------------------------------------------------------------------------
// simple_uart
// Minimal memory-mapped 8N1 UART: 32-bit programmable divider, single-byte
// receive buffer (simple_uart_rx) and single-byte transmit shifter.
// Ports:
//   clk           in   system clock
//   resetn        in   synchronous reset, active-low
//   ser_tx        out  serial transmit line, idles high
//   ser_rx        in   serial receive line, idles high
//   reg_div_we    in   byte-lane write enables for the divider
//   reg_div_di    in   divider write data
//   reg_div_do    out  current divider value
//   reg_dat_we    in   transmit-byte write request (held until wait drops)
//   reg_dat_re    in   receive-buffer read strobe
//   reg_dat_di    in   transmit data, [7:0] used
//   reg_dat_do    out  receive data or 32'hFFFF_FFFF when empty
//   reg_dat_wait  out  transmitter busy, write not accepted this cycle
// Build option: SIMPLE_UART_RX_SYNC_EN (see simple_uart_rx).
// -----------------------------------------------------------------------------
module simple_uart
    import simple_uart_pkg::*;
#(
    parameter logic [31:0] DIV_RESET = 32'd1
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        ser_tx,
    input  logic        ser_rx,
    input  logic [3:0]  reg_div_we,
    input  logic [31:0] reg_div_di,
    output logic [31:0] reg_div_do,
    input  logic        reg_dat_we,
    input  logic        reg_dat_re,
    input  logic [31:0] reg_dat_di,
    output logic [31:0] reg_dat_do,
    output logic        reg_dat_wait
);

    logic [31:0] r_cfg_div;
    logic        r_send_dummy;
    logic [9:0]  r_pattern;
    logic [3:0]  r_bitcnt;
    logic [31:0] r_tx_cnt;
    logic        w_tx_idle;
    logic        w_unused_dat;

    assign w_tx_idle    = (r_bitcnt == 4'd0);
    assign reg_div_do   = r_cfg_div;
    assign reg_dat_wait = reg_dat_we && (!w_tx_idle || r_send_dummy);
    assign ser_tx       = r_pattern[0];
    assign w_unused_dat = ^reg_dat_di[31:8];

    // Divider register with per-byte-lane writes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cfg_div <= DIV_RESET;
        end else begin
            r_cfg_div <= merge_lanes(r_cfg_div, reg_div_di, reg_div_we);
        end
    end

    // Transmit shifter: dummy idle period, byte load, then one shift per bit time.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pattern    <= 10'h3FF;
            r_bitcnt     <= 4'd0;
            r_tx_cnt     <= 32'd0;
            r_send_dummy <= 1'b1;
        end else begin
            r_tx_cnt <= r_tx_cnt + 32'd1;
            if (r_send_dummy && w_tx_idle) begin
                r_pattern    <= 10'h3FF;
                r_bitcnt     <= 4'(DUMMY_BITS);
                r_tx_cnt     <= 32'd0;
                r_send_dummy <= 1'b0;
            end else if (reg_dat_we && w_tx_idle) begin
                r_pattern <= {1'b1, reg_dat_di[7:0], 1'b0};
                r_bitcnt  <= 4'(FRAME_BITS);
                r_tx_cnt  <= 32'd0;
            end else if (!w_tx_idle && (r_tx_cnt > r_cfg_div)) begin
                r_pattern <= {1'b1, r_pattern[9:1]};
                r_bitcnt  <= r_bitcnt - 4'd1;
                r_tx_cnt  <= 32'd0;
            end
            // A divider change re-arms the idle period so the far end can resync.
            if (|reg_div_we) begin
                r_send_dummy <= 1'b1;
            end
        end
    end

    simple_uart_rx u_rx (
        .clk       (clk),
        .resetn    (resetn),
        .i_rx      (ser_rx),
        .i_cfg_div (r_cfg_div),
        .i_dat_re  (reg_dat_re),
        .o_dat_do  (reg_dat_do)
    );

endmodule

// File: tb/tb_simple_uart.sv
module tb_simple_uart;

`ifdef SIMPLE_UART_RX_SYNC_EN
    localparam int SYNC_DLY = 2;
`else
    localparam int SYNC_DLY = 0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ser_tx;
    logic        ser_rx = 1'b1;
    logic [3:0]  reg_div_we = 4'd0;
    logic [31:0] reg_div_di = 32'd0;
    logic [31:0] reg_div_do;
    logic        reg_dat_we = 1'b0;
    logic        reg_dat_re = 1'b0;
    logic [31:0] reg_dat_di = 32'd0;
    logic [31:0] reg_dat_do;
    logic        reg_dat_wait;

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] model_div = 32'd1;

    typedef struct packed {
        logic [3:0]  we;
        logic [31:0] di;
        logic [31:0] exp_do;
    } div_vec_t;

    div_vec_t tbl [5];

    simple_uart dut (
        .clk          (clk),
        .resetn       (resetn),
        .ser_tx       (ser_tx),
        .ser_rx       (ser_rx),
        .reg_div_we   (reg_div_we),
        .reg_div_di   (reg_div_di),
        .reg_div_do   (reg_div_do),
        .reg_dat_we   (reg_dat_we),
        .reg_dat_re   (reg_dat_re),
        .reg_dat_di   (reg_dat_di),
        .reg_dat_do   (reg_dat_do),
        .reg_dat_wait (reg_dat_wait)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        reg_dat_we = 1'b0;
        reg_dat_re = 1'b0;
        reg_div_we = 4'd0;
        ser_rx = 1'b1;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        model_div = 32'd1;
        #1;
    endtask

    task automatic div_write(input logic [3:0] we, input logic [31:0] d);
        reg_div_we = we;
        reg_div_di = d;
        @(negedge clk);
        reg_div_we = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (we[i]) model_div[8*i +: 8] = d[8*i +: 8];
        end
    endtask

    // Hold the write until accepted; exp_wait<0 skips the wait-length comparison.
    task automatic tx_accept(input logic [7:0] b, input int exp_wait);
        int n;
        n = 0;
        reg_dat_we = 1'b1;
        reg_dat_di = {24'($urandom), b};
        #1;
        while (reg_dat_wait && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 3000) chk("tx_accept_timeout", 32'(n), 32'(exp_wait));
        else if (exp_wait >= 0) chk("tx_wait_cycles", 32'(n), 32'(exp_wait));
    endtask

    // Compare ser_tx against the ideal frame; ncyc<=0 means the whole frame.
    task automatic tx_check(input logic [7:0] b, input bit hold_next, input logic [7:0] nb,
                            input int ncyc, input int idle_after);
        int T;
        int len;
        logic [9:0] fr;
        T = int'(model_div) + 2;
        fr = {1'b1, b, 1'b0};
        len = (ncyc > 0) ? ncyc : 10 * T;
        @(negedge clk);
        reg_dat_we = hold_next;
        reg_dat_di = {24'($urandom), nb};
        for (int j = 0; j < len; j++) begin
            #1;
            chk("tx_bit", {31'd0, ser_tx}, {31'd0, fr[j / T]});
            if (hold_next) chk("tx_busy_wait", {31'd0, reg_dat_wait}, 32'd1);
            @(negedge clk);
        end
        for (int k = 0; k < idle_after; k++) begin
            #1;
            chk("tx_idle", {31'd0, ser_tx}, 32'd1);
            @(negedge clk);
        end
    endtask

    // Drive one 8N1 frame; reg_dat_re is high for frame-cycle offsets re_from..re_to.
    task automatic rx_frame(input logic [7:0] b, input int T, input int re_from, input int re_to);
        logic [9:0] fr;
        int idx;
        fr = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < T; j++) begin
                idx = k * T + j;
                ser_rx = fr[k];
                reg_dat_re = (idx >= re_from) && (idx <= re_to);
                @(negedge clk);
            end
        end
        reg_dat_re = 1'b0;
        ser_rx = 1'b1;
    endtask

    initial begin
        logic [7:0] rb;
        logic [7:0] tb_byte;
        int d;
        int c;

        tbl[0] = '{we: 4'b1111, di: 32'h1122_3344, exp_do: 32'h1122_3344};
        tbl[1] = '{we: 4'b0001, di: 32'h0000_00AA, exp_do: 32'h1122_33AA};
        tbl[2] = '{we: 4'b0100, di: 32'h00FF_0000, exp_do: 32'h11FF_33AA};
        tbl[3] = '{we: 4'b1010, di: 32'hDE00_BE00, exp_do: 32'hDEFF_BEAA};
        tbl[4] = '{we: 4'b0000, di: 32'hFFFF_FFFF, exp_do: 32'hDEFF_BEAA};

        @(negedge clk);
        do_reset();
        chk("rst_ser_tx", {31'd0, ser_tx}, 32'd1);
        chk("rst_div_do", reg_div_do, 32'd1);
        chk("rst_dat_do", reg_dat_do, 32'hFFFF_FFFF);

        // One cycle to load the idle pattern, then 15 bit times of 3 clocks.
        tx_accept(8'h3C, 1 + 15 * 3);
        tx_check(8'h3C, 1'b0, 8'h00, 0, 3);

        for (int i = 0; i < 5; i++) begin
            reg_div_we = tbl[i].we;
            reg_div_di = tbl[i].di;
            @(negedge clk);
            reg_div_we = 4'd0;
            #1;
            chk("div_lanes", reg_div_do, tbl[i].exp_do);
            if (tbl[i].we != 4'd0) begin
                reg_dat_we = 1'b1;
                #1;
                chk("div_rearm_wait", {31'd0, reg_dat_wait}, 32'd1);
                reg_dat_we = 1'b0;
            end
            @(negedge clk);
        end

        do_reset();
        chk("rst2_div_do", reg_div_do, 32'd1);
        repeat (50) @(negedge clk);

        // 0x55 at divider 8 with a second write held during the frame.
        div_write(4'hF, 32'd8);
        tx_accept(8'h55, 1 + 15 * 10);
        tx_check(8'h55, 1'b1, 8'hA0, 0, 0);
        tx_accept(8'hA0, 0);
        tx_check(8'hA0, 1'b0, 8'h00, 0, 3);

        // Same-value divider write still re-arms the idle period.
        div_write(4'hF, 32'd8);
        tx_accept(8'h0F, 1 + 15 * 10);
        tx_check(8'h0F, 1'b0, 8'h00, 0, 2);

        // Receive path at divider 8.
        rx_frame(8'hA5, 10, -1, -1);
        #1;
        chk("rx_a5", reg_dat_do, 32'h0000_00A5);
        reg_dat_re = 1'b1;
        #1;
        chk("rx_before_read", reg_dat_do, 32'h0000_00A5);
        @(negedge clk);
        reg_dat_re = 1'b0;
        #1;
        chk("rx_after_read", reg_dat_do, 32'hFFFF_FFFF);
        rx_frame(8'h12, 10, -1, -1);
        rx_frame(8'h34, 10, -1, -1);
        #1;
        chk("rx_overrun", reg_dat_do, 32'h0000_0034);
        // Read held from the stop bit up to the completion cycle: new byte must win.
        c = SYNC_DLY + 8 / 2 + 2 + 9 * 10;
        rx_frame(8'h5A, 10, 90, c);
        #1;
        chk("rx_read_collision", reg_dat_do, 32'h0000_005A);
        reg_dat_re = 1'b1;
        @(negedge clk);
        reg_dat_re = 1'b0;
        #1;
        chk("rx_cleared", reg_dat_do, 32'hFFFF_FFFF);

        // Randomized TX/RX against the frame model.
        for (int it = 0; it < 6; it++) begin
            d = $urandom_range(14, 6);
            div_write(4'hF, 32'(d));
            #1;
            chk("rand_div_do", reg_div_do, 32'(d));
            tb_byte = 8'($urandom);
            tx_accept(tb_byte, 1 + 15 * (d + 2));
            tx_check(tb_byte, 1'b0, 8'h00, 0, 2);
            rb = 8'($urandom);
            rx_frame(rb, d + 2, -1, -1);
            #1;
            chk("rand_rx", reg_dat_do, {24'd0, rb});
            reg_dat_re = 1'b1;
            @(negedge clk);
            reg_dat_re = 1'b0;
        end

        // Divider 0: two-clock bit time.
        div_write(4'hF, 32'd0);
        tx_accept(8'hE7, 1 + 15 * 2);
        tx_check(8'hE7, 1'b0, 8'h00, 0, 2);

        // Reset during data bit 3 of 0x55 (a low bit).
        div_write(4'hF, 32'd8);
        tx_accept(8'h55, 1 + 15 * 10);
        tx_check(8'h55, 1'b0, 8'h00, 45, 0);
        resetn = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_mid_tx_ser", {31'd0, ser_tx}, 32'd1);
        resetn = 1'b1;
        model_div = 32'd1;
        chk("rst_mid_tx_div", reg_div_do, 32'd1);
        tx_accept(8'h81, 1 + 15 * 3);
        tx_check(8'h81, 1'b0, 8'h00, 0, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
